// File: rtl/lsu_pkg.sv
// Shared types for the load/store sequencer: FSM states, access size codes,
// exception codes and the alignment rule.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_MEM  = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_RSVD = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_LMIS = 2'b01;
  localparam logic [1:0] EXC_SMIS = 2'b10;
  localparam logic [1:0] EXC_BUS  = 2'b11;

  // The reserved size code is reported as a misalignment so it never reaches memory.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    misaligned = (size == SZ_RSVD) ||
                 ((size == SZ_HALF) && lo[0]) ||
                 ((size == SZ_WORD) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Pipeline-side request/response and data-memory port of lsu_ctrl, bundled
// with a slave modport (the sequencer) and a master modport (its environment).
interface lsu_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Handshakes: a request is taken on a rising clk edge where i_valid & o_ready;
  // o_mem_req stays high with stable attributes until the edge that samples
  // i_mem_ack; o_done is a single-cycle pulse and o_rdata/o_exc hold until the next one.
  logic              i_valid;
  logic              o_ready;
  logic              i_we;
  logic [1:0]        i_size;
  logic              i_unsigned;
  logic [ADDR_W-1:0] i_base;
  logic [15:0]       i_offset;
  logic [DATA_W-1:0] i_wdata;

  logic              o_mem_req;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [3:0]        o_mem_be;
  logic [DATA_W-1:0] o_mem_wdata;
  logic              i_mem_ack;
  logic [DATA_W-1:0] i_mem_rdata;

  logic              o_done;
  logic [DATA_W-1:0] o_rdata;
  logic [1:0]        o_exc;
  logic [ADDR_W-1:0] o_bad_addr;

  modport slave (
    input  i_valid, i_we, i_size, i_unsigned, i_base, i_offset, i_wdata,
    input  i_mem_ack, i_mem_rdata,
    output o_ready, o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata,
    output o_done, o_rdata, o_exc, o_bad_addr
  );

  modport master (
    output i_valid, i_we, i_size, i_unsigned, i_base, i_offset, i_wdata,
    output i_mem_ack, i_mem_rdata,
    input  o_ready, o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata,
    input  o_done, o_rdata, o_exc, o_bad_addr
  );
endinterface

// File: rtl/lsu_lane.sv
// Little-endian byte-lane steering: store byte enables and replicated data,
// and load lane extraction with sign or zero extension.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  i_lo,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ldata
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v  = i_rdata[{i_lo, 3'b000} +: 8];
    half_v  = i_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_be    = 4'b0000;
    o_wdata = i_wdata;
    o_ldata = i_rdata;
    case (i_size)
      SZ_BYTE: begin
        o_be    = 4'b0001 << i_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_ldata = {{24{~i_unsigned & byte_v[7]}}, byte_v};
      end
      SZ_HALF: begin
        o_be    = i_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
        o_ldata = {{16{~i_unsigned & half_v[15]}}, half_v};
      end
      SZ_WORD: begin
        o_be    = 4'b1111;
      end
      default: begin
        o_be    = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between EX and the data memory port.
// Optional bus timeout in MEM is enabled by defining LSU_TIMEOUT_EN.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
`ifdef LSU_TIMEOUT_EN
  , parameter int TIMEOUT = 15
`endif
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  lsu_ctrl_if.slave  bus,
  output state_t     o_state
);

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  state_t            state_q, state_d;
  logic              ready_q, ready_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [15:0]       offset_q, offset_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        exc_q, exc_d;
  logic [ADDR_W-1:0] bad_addr_q, bad_addr_d;

  logic [ADDR_W-1:0] eff;
  logic [3:0]        lane_be;
  logic [31:0]       lane_wdata;
  logic [31:0]       lane_ldata;

  // base/offset are frozen from accept until RESP, so eff is valid in ADDR and MEM.
  assign eff = base_q + {{(ADDR_W-16){offset_q[15]}}, offset_q};

  lsu_lane u_lane (
    .i_lo       (eff[1:0]),
    .i_size     (size_q),
    .i_unsigned (uns_q),
    .i_wdata    (wdata_q),
    .i_rdata    (bus.i_mem_rdata),
    .o_be       (lane_be),
    .o_wdata    (lane_wdata),
    .o_ldata    (lane_ldata)
  );

  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    base_d      = base_q;
    offset_d    = offset_q;
    wdata_d     = wdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    rdata_d     = rdata_q;
    exc_d       = exc_q;
    bad_addr_d  = bad_addr_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.i_valid) begin
          we_d     = bus.i_we;
          size_d   = bus.i_size;
          uns_d    = bus.i_unsigned;
          base_d   = bus.i_base;
          offset_d = bus.i_offset;
          wdata_d  = bus.i_wdata;
          ready_d  = 1'b0;
          state_d  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (misaligned(size_q, eff[1:0])) begin
          exc_d      = we_q ? EXC_SMIS : EXC_LMIS;
          bad_addr_d = eff;
          done_d     = 1'b1;
          state_d    = ST_RESP;
        end else begin
          mem_req_d   = 1'b1;
          mem_we_d    = we_q;
          mem_addr_d  = {eff[ADDR_W-1:2], 2'b00};
          mem_be_d    = lane_be;
          mem_wdata_d = lane_wdata;
`ifdef LSU_TIMEOUT_EN
          cnt_d       = '0;
`endif
          state_d     = ST_MEM;
        end
      end
      ST_MEM: begin
        if (bus.i_mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (!we_q) rdata_d = lane_ldata;
          exc_d     = EXC_NONE;
          done_d    = 1'b1;
          state_d   = ST_RESP;
`ifdef LSU_TIMEOUT_EN
        // This cycle's missing ack is the one that brings the count to TIMEOUT.
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          exc_d      = EXC_BUS;
          bad_addr_d = eff;
          done_d     = 1'b1;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      ST_RESP: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b1;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      base_q      <= '0;
      offset_q    <= '0;
      wdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      rdata_q     <= '0;
      exc_q       <= EXC_NONE;
      bad_addr_q  <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      base_q      <= base_d;
      offset_q    <= offset_d;
      wdata_q     <= wdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      exc_q       <= exc_d;
      bad_addr_q  <= bad_addr_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign bus.o_ready     = ready_q;
  assign bus.o_mem_req   = mem_req_q;
  assign bus.o_mem_we    = mem_we_q;
  assign bus.o_mem_addr  = mem_addr_q;
  assign bus.o_mem_be    = mem_be_q;
  assign bus.o_mem_wdata = mem_wdata_q;
  assign bus.o_done      = done_q;
  assign bus.o_rdata     = rdata_q;
  assign bus.o_exc       = exc_q;
  assign bus.o_bad_addr  = bad_addr_q;
  assign o_state         = state_q;

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencer between the EX stage and the data memory port. Accepts one memory request at a time, forms the effective address (base + sign-extended 16-bit offset) and checks alignment against the access size. It then drives a req/ack handshake to data memory, with byte-lane enables for stores and lane extraction plus sign/zero extension for loads. Results and address exceptions are returned to the pipeline with a one-cycle done pulse.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (fixed at 32; byte lanes assume 4)
- TIMEOUT, 15, max MEM cycles without ack (used only with LSU_TIMEOUT_EN)

- i_clk  in  1  clock
- i_rst_n  in  1  reset; one clock, reset is synchronous and active-low
- i_valid  in  1  request from EX
- o_ready  out  1  high in IDLE; request accepted when i_valid & o_ready
- i_we  in  1  1 = store, 0 = load
- i_size  in  2  00 byte, 01 half, 11 word, 10 reserved
- i_unsigned  in  1  load zero-extends when 1
- i_base  in  32  base register value
- i_offset  in  16  signed offset
- i_wdata  in  32  store data (low bits significant)
- o_mem_req  out  1  memory request, held until ack
- o_mem_we  out  1  write strobe
- o_mem_addr  out  32  word address, bits [1:0] = 0
- o_mem_be  out  4  byte enables
- o_mem_wdata  out  32  lane-replicated store data
- i_mem_ack  in  1  memory completion
- i_mem_rdata  in  32  read word, valid with ack
- o_done  out  1  one-cycle completion pulse
- o_rdata  out  32  extended load result, held until next done
- o_exc  out  2  00 none, 01 load misaligned, 10 store misaligned, 11 bus timeout
- o_bad_addr  out  32  effective address of the faulting request

## Operation
- FSM states: IDLE, ADDR, MEM, RESP.
- IDLE: o_ready = 1. On i_valid, register we/size/unsigned/base/offset/wdata, then go to ADDR.
- ADDR: eff = base + sext(offset), registered, mod 2^32 wrap. Misaligned when half & eff[0], word & eff[1:0] ≠ 0, or size = 10.
  - Misaligned: o_exc = 01 (load) or 10 (store), o_bad_addr = eff, then RESP. No memory access is made.
  - Aligned: go to MEM.
- MEM: o_mem_req = 1, with addr/be/wdata/we stable until the ack cycle.
  - Byte lanes are little-endian. Byte uses be = 1 << eff[1:0] with wdata = byte ×4. Half uses be = 0011 (eff[1] = 0) or 1100 (eff[1] = 1) with wdata = half ×2. Word uses be = 1111.
  - On i_mem_ack, drop req next cycle. For loads, latch the extracted lane into o_rdata, sign- or zero-extended. Go to RESP.
- RESP: o_done = 1 for one cycle, o_exc valid, then IDLE. o_exc holds until the next done. o_rdata is unchanged for stores and faults.
- i_mem_ack outside MEM is ignored.
- Reset: all registered outputs go to 0 and the state to IDLE, so o_ready = 1 after reset. Reset mid-MEM drops o_mem_req at that edge; a late ack is ignored.

## Timing
- Accept edge T. ADDR occupies T+1; MEM starts T+2.
- If ack arrives in the first MEM cycle, o_done is high in cycle T+3. Each extra wait cycle adds 1.
- Misaligned request: o_done is high in cycle T+2.
- o_ready is low from T+1 until the cycle after done. A new request can be accepted in the cycle after o_done.
- o_mem_req is registered and has no combinational path from i_mem_ack.

## Configuration
- LSU_TIMEOUT_EN defined:
  - A counter clears on MEM entry and increments every MEM cycle without ack.
  - When it reaches TIMEOUT, drop req, set o_exc = 11 and o_bad_addr = eff, then go to RESP.
  - Ack in the same cycle as the count reaching TIMEOUT wins, giving a normal completion.
- LSU_TIMEOUT_EN undefined: MEM waits indefinitely, the counter does not exist and o_exc never takes 11.

## Structure
- Package lsu_pkg: state encoding, size codes (SZ_BYTE, SZ_HALF, SZ_WORD), exception codes (EXC_NONE, EXC_LMIS, EXC_SMIS, EXC_BUS).
- Sub-module lsu_lane (combinational) takes eff[1:0], size, unsigned, wdata and rdata, and produces be, replicated wdata and extended load data.

## Test plan
- Load word: base 0x1000, off 0x0004, rdata 0xDEADBEEF, ack in first MEM cycle -> mem_addr 0x1004, be 1111, done at T+3, o_rdata 0xDEADBEEF, exc 00.
- Signed byte load: base 0x2003, off 0x0000, rdata 0x80FF_FF7F -> be 1000, o_rdata 0xFFFFFF80. Same with i_unsigned = 1 -> 0x00000080.
- Store half with negative offset: base 0x3000, off 0xFFFE, wdata 0x1234 -> addr 0x2FFC, be 1100, wdata 0x12341234, we 1.
- Misaligned: load word at 0x1002 -> no mem_req, done at T+2, exc 01, bad_addr 0x1002. Store half at 0x1001 -> exc 10.
- Wait states and reset: ack delayed 5 cycles -> req held with stable outputs, done at T+8. Reset asserted in MEM -> next cycle req 0, o_ready 1, no done.
- With LSU_TIMEOUT_EN, TIMEOUT 15 and no ack -> req drops after 15 MEM cycles, done with exc 11. Ack on cycle 15 -> normal completion.
